// File: rtl/oled_spi_driver.sv
// oled_spi_driver: SSD1306 128x64 power sequence, fixed init table, then endless horizontal-mode frame refresh over 4-wire SPI.
// Latency: command byte 16*SCLK_HALF+2 clk, data byte 16*SCLK_HALF+3 clk; pixelData sampled 2 clk after pixelAddress moves.
// Backpressure: none; the pixel source must answer each address with a 1-clk registered read. Define OLED_FRAME_PULSE_EN for frameDone.
module oled_spi_driver #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter logic [7:0]  SCLK_HALF    = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset
`ifdef OLED_FRAME_PULSE_EN
  , output logic     frameDone
`endif
);

  typedef enum logic [2:0] {
    POWER_WAIT1, POWER_RESET, POWER_WAIT2, LOAD_CMD, SEND, CHECK, FETCH1, FETCH2
  } state_t;

  localparam logic [4:0] LAST_CMD = 5'd20;

  state_t      state;
  logic [31:0] waitCnt;
  logic [7:0]  halfCnt;
  logic [2:0]  bitCnt;
  logic [4:0]  cmdIdx;
  logic [7:0]  shiftReg;
  logic [7:0]  initByte;

  // Panel init table: display off, clocking, mux, offsets, charge pump, horizontal addressing, remap, contrast, display on.
  always_comb begin
    initByte = 8'hE3;
    case (cmdIdx)
      5'd0:  initByte = 8'hAE;
      5'd1:  initByte = 8'hD5;
      5'd2:  initByte = 8'h80;
      5'd3:  initByte = 8'hA8;
      5'd4:  initByte = 8'h3F;
      5'd5:  initByte = 8'hD3;
      5'd6:  initByte = 8'h00;
      5'd7:  initByte = 8'h40;
      5'd8:  initByte = 8'h8D;
      5'd9:  initByte = 8'h14;
      5'd10: initByte = 8'h20;
      5'd11: initByte = 8'h00;
      5'd12: initByte = 8'hA1;
      5'd13: initByte = 8'hC8;
      5'd14: initByte = 8'hDA;
      5'd15: initByte = 8'h12;
      5'd16: initByte = 8'h81;
      5'd17: initByte = 8'h7F;
      5'd18: initByte = 8'hA4;
      5'd19: initByte = 8'hA6;
      5'd20: initByte = 8'hAF;
      default: initByte = 8'hE3;
    endcase
  end

  // Sequencer: power phases, byte load, bit serialiser and byte bookkeeping; all pins are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= POWER_WAIT1;
      waitCnt      <= 32'd0;
      halfCnt      <= 8'd0;
      bitCnt       <= 3'd0;
      cmdIdx       <= 5'd0;
      shiftReg     <= 8'd0;
      pixelAddress <= 10'd0;
      io_sclk      <= 1'b1;
      io_sdin      <= 1'b0;
      io_cs        <= 1'b1;
      io_dc        <= 1'b0;
      io_reset     <= 1'b1;
`ifdef OLED_FRAME_PULSE_EN
      frameDone    <= 1'b0;
`endif
    end else begin
`ifdef OLED_FRAME_PULSE_EN
      frameDone <= 1'b0;
`endif
      case (state)
        POWER_WAIT1: begin
          if (waitCnt == STARTUP_WAIT - 32'd1) begin
            waitCnt  <= 32'd0;
            io_reset <= 1'b0;
            state    <= POWER_RESET;
          end else begin
            waitCnt <= waitCnt + 32'd1;
          end
        end
        POWER_RESET: begin
          if (waitCnt == STARTUP_WAIT - 32'd1) begin
            waitCnt  <= 32'd0;
            io_reset <= 1'b1;
            state    <= POWER_WAIT2;
          end else begin
            waitCnt <= waitCnt + 32'd1;
          end
        end
        POWER_WAIT2: begin
          if (waitCnt == STARTUP_WAIT - 32'd1) begin
            waitCnt <= 32'd0;
            state   <= LOAD_CMD;
          end else begin
            waitCnt <= waitCnt + 32'd1;
          end
        end
        LOAD_CMD: begin
          shiftReg <= initByte;
          io_sdin  <= initByte[7];
          io_dc    <= 1'b0;
          io_cs    <= 1'b0;
          io_sclk  <= 1'b0;
          halfCnt  <= 8'd0;
          bitCnt   <= 3'd0;
          state    <= SEND;
        end
        SEND: begin
          // Data only moves at the end of a high half, so it is always set up while SCLK is low.
          if (halfCnt == SCLK_HALF - 8'd1) begin
            halfCnt <= 8'd0;
            if (!io_sclk) begin
              io_sclk <= 1'b1;
            end else if (bitCnt == 3'd7) begin
              state <= CHECK;
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              io_sclk  <= 1'b0;
              io_sdin  <= shiftReg[6];
              shiftReg <= {shiftReg[6:0], 1'b0};
            end
          end else begin
            halfCnt <= halfCnt + 8'd1;
          end
        end
        CHECK: begin
          // io_dc still tells whether the byte just sent was a command or pixel data.
          if (!io_dc) begin
            if (cmdIdx == LAST_CMD) begin
              state <= FETCH1;
            end else begin
              cmdIdx <= cmdIdx + 5'd1;
              state  <= LOAD_CMD;
            end
          end else begin
            pixelAddress <= pixelAddress + 10'd1;
`ifdef OLED_FRAME_PULSE_EN
            frameDone    <= &pixelAddress;
`endif
            state        <= FETCH1;
          end
        end
        FETCH1: begin
          state <= FETCH2;
        end
        FETCH2: begin
          shiftReg <= pixelData;
          io_sdin  <= pixelData[7];
          io_dc    <= 1'b1;
          io_sclk  <= 1'b0;
          halfCnt  <= 8'd0;
          bitCnt   <= 3'd0;
          state    <= SEND;
        end
        default: state <= POWER_WAIT1;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: two instances (SCLK_HALF 1 and 3, STARTUP_WAIT 4) fed by registered pixel sources.
// Expected pins come from a cycle-index model of the power/init/refresh schedule plus an SPI byte decoder.
// Instance A is reset mid data byte after its first frame wrap and must replay the whole sequence.
`timescale 1ns/1ps
module tb_oled_spi_driver;

  localparam int W  = 4;
  localparam int HA = 1;
  localparam int HB = 3;

  typedef struct packed {
    bit       ioReset;
    bit       cs;
    bit       sclk;
    bit       inSend;
    bit       sdin;
    bit       dc;
    bit       frame;
    bit [9:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetA, resetB;
  logic [9:0] addrA, addrB;
  logic [7:0] pixA, pixB;
  logic       sclkA, sdinA, csA, dcA, panRstA;
  logic       sclkB, sdinB, csB, dcB, panRstB;
  logic       frmA, frmB;
  bit         rstQA = 1'b1;
  bit         rstQB = 1'b1;

`ifndef OLED_FRAME_PULSE_EN
  assign frmA = 1'b0;
  assign frmB = 1'b0;
`endif

  oled_spi_driver #(.STARTUP_WAIT(32'd4), .SCLK_HALF(8'd1)) dutA (
    .clk(clk), .reset(resetA), .pixelAddress(addrA), .pixelData(pixA),
    .io_sclk(sclkA), .io_sdin(sdinA), .io_cs(csA), .io_dc(dcA), .io_reset(panRstA)
`ifdef OLED_FRAME_PULSE_EN
    , .frameDone(frmA)
`endif
  );

  oled_spi_driver #(.STARTUP_WAIT(32'd4), .SCLK_HALF(8'd3)) dutB (
    .clk(clk), .reset(resetB), .pixelAddress(addrB), .pixelData(pixB),
    .io_sclk(sclkB), .io_sdin(sdinB), .io_cs(csB), .io_dc(dcB), .io_reset(panRstB)
`ifdef OLED_FRAME_PULSE_EN
    , .frameDone(frmB)
`endif
  );

  // Registered pixel sources returning the low address byte, plus a record of what reset each edge saw.
  always @(posedge clk) begin
    pixA  <= addrA[7:0];
    pixB  <= addrB[7:0];
    rstQA <= resetA;
    rstQB <= resetB;
  end

  logic [7:0] initTbl [0:20];
  int nChecks = 0;
  int nFail   = 0;
  int tCyc [2];
  int run [2];
  bit prevSclk [2];
  int bitN [2];
  logic [7:0] shReg [2];
  int byteIdx [2];
  int cmdBytes [2];
  int frameCnt [2];
  int ioRstFall [2];
  int csFall [2];
  int addr1 [2];
  int firstRise [2];
  logic [7:0] firstBytes [0:22];

  task automatic check(input string name, input int id, input int act, input int expv);
    nChecks++;
    if (act != expv) begin
      nFail++;
      $display("FAIL %s dut%0d t=%0d: got %0h, expected %0h", name, id, tCyc[id], act, expv);
    end
  endtask

  // Pin values at cycle t after reset release, from the byte schedule alone.
  function automatic exp_t model(input int t, input int h);
    exp_t e;
    int cp, dp, c0, d0, i, o, j, s;
    logic [7:0] b;
    cp = 16*h + 2;
    dp = 16*h + 3;
    c0 = 3*W;
    d0 = c0 + 21*cp;
    e = '0;
    e.sclk = 1'b1;
    e.ioReset = !(t >= W && t < 2*W);
    e.cs = (t <= c0);
    b = 8'h00;
    s = -1;
    if (t >= c0 && t < d0) begin
      i = (t - c0) / cp;
      o = (t - c0) % cp;
      if (o >= 1 && o <= 16*h) begin
        s = o - 1;
        b = initTbl[i];
        e.dc = 1'b0;
      end
    end else if (t >= d0) begin
      j = (t - d0) / dp;
      o = (t - d0) % dp;
      e.addr = 10'(j % 1024);
      e.frame = (o == 0 && j > 0 && j % 1024 == 0);
      if (o >= 2 && o <= 16*h + 1) begin
        s = o - 2;
        b = 8'(j % 256);
        e.dc = 1'b1;
      end
    end
    if (s >= 0) begin
      e.inSend = 1'b1;
      e.sclk = (s % (2*h)) >= h;
      e.sdin = b[7 - s/(2*h)];
    end
    return e;
  endfunction

  task automatic observe(input int id, input int h, input bit rq, input logic [9:0] addr,
                         input logic sclk, input logic sdin, input logic cs, input logic dc,
                         input logic prst, input logic frm);
    int t;
    int n;
    exp_t e;
    logic [7:0] expb;
    t = rq ? 0 : tCyc[id];
    e = model(t, h);
    check("io_reset", id, prst, e.ioReset);
    check("io_cs", id, cs, e.cs);
    check("io_sclk", id, sclk, e.sclk);
    check("pixelAddress", id, addr, e.addr);
    if (e.inSend) begin
      check("io_sdin", id, sdin, e.sdin);
      check("io_dc", id, dc, e.dc);
    end
`ifdef OLED_FRAME_PULSE_EN
    check("frameDone", id, frm, e.frame);
`endif
    if (frm && run[id] == 0) frameCnt[id]++;
    if (rq) begin
      bitN[id] = 0;
      byteIdx[id] = 0;
      prevSclk[id] = 1'b1;
      tCyc[id] = 1;
    end else begin
      if (run[id] == 0) begin
        if (prst == 1'b0 && ioRstFall[id] < 0) ioRstFall[id] = t;
        if (cs == 1'b0 && csFall[id] < 0) csFall[id] = t;
        if (addr == 10'd1 && addr1[id] < 0) addr1[id] = t;
        if (!prevSclk[id] && sclk && firstRise[id] < 0) firstRise[id] = t;
      end
      if (!prevSclk[id] && sclk) begin
        shReg[id] = {shReg[id][6:0], sdin};
        bitN[id]++;
        if (bitN[id] == 8) begin
          n = byteIdx[id];
          expb = (n < 21) ? initTbl[n] : 8'((n - 21) % 256);
          check("spi_byte", id, shReg[id], expb);
          check("spi_byte_dc", id, dc, (n >= 21) ? 1 : 0);
          if (run[id] == 0) begin
            if (id == 0 && n < 23) firstBytes[n] = shReg[id];
            if (dc == 1'b0) cmdBytes[id]++;
          end
          byteIdx[id]++;
          bitN[id] = 0;
        end
      end
      prevSclk[id] = sclk;
      tCyc[id]++;
    end
  endtask

  always @(negedge clk) begin
    observe(0, HA, rstQA, addrA, sclkA, sdinA, csA, dcA, panRstA, frmA);
    observe(1, HB, rstQB, addrB, sclkB, sdinB, csB, dcB, panRstB, frmB);
  end

  initial begin
    int kRst;
    int extra;
    resetA = 1'b1;
    resetB = 1'b1;
    initTbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20,
                8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'h7F, 8'hA4, 8'hA6, 8'hAF};
    for (int i = 0; i < 2; i++) begin
      tCyc[i] = 0; run[i] = 0; prevSclk[i] = 1'b1; bitN[i] = 0; shReg[i] = 8'h00;
      byteIdx[i] = 0; cmdBytes[i] = 0; frameCnt[i] = 0;
      ioRstFall[i] = -1; csFall[i] = -1; addr1[i] = -1; firstRise[i] = -1;
    end
    for (int i = 0; i < 23; i++) firstBytes[i] = 8'hxx;
    repeat (2) @(posedge clk);
    #1 resetA = 1'b0;
    resetB = 1'b0;
    // Cycle kRst of instance A is the first low half of bit 3 of data byte 1030 (address 6, second frame).
    kRst = 3*W + 21*(16*HA + 2) + 1030*(16*HA + 3) + 2 + 3*2*HA;
    extra = $urandom_range(0, 3) * 19;
    kRst = kRst + extra;
    repeat (kRst) @(posedge clk);
    #1 resetA = 1'b1;
    @(negedge clk);
    check("abort_sclk_low", 0, sclkA, 0);
    check("abort_dc", 0, dcA, 1);
    check("abort_addr", 0, addrA, 6 + extra/19);
    @(negedge clk);
    run[0] = 1;
    check("rst_cs", 0, csA, 1);
    check("rst_sclk", 0, sclkA, 1);
    check("rst_addr", 0, addrA, 0);
    check("rst_io_reset", 0, panRstA, 1);
    @(posedge clk);
    #1 resetA = 1'b0;
    repeat (800) @(posedge clk);
    @(negedge clk);
    #1;
    check("io_reset_fall_cycle", 0, ioRstFall[0], 4);
    check("cs_fall_cycle", 0, csFall[0], 13);
    check("cs_fall_cycle", 1, csFall[1], 13);
    check("first_sclk_rise", 0, firstRise[0], 14);
    check("first_sclk_rise", 1, firstRise[1], 16);
    check("addr1_cycle", 0, addr1[0], 409);
    check("addr1_cycle", 1, addr1[1], 1113);
    check("first_cmd_byte", 0, firstBytes[0], 8'hAE);
    check("last_cmd_byte", 0, firstBytes[20], 8'hAF);
    check("first_data_byte", 0, firstBytes[21], 8'h00);
    check("second_data_byte", 0, firstBytes[22], 8'h01);
    check("cmd_byte_count", 0, cmdBytes[0], 21);
    check("cmd_byte_count", 1, cmdBytes[1], 21);
    check("replay_byte_count", 0, (byteIdx[0] > 21) ? 1 : 0, 1);
`ifdef OLED_FRAME_PULSE_EN
    check("frame_pulses", 0, frameCnt[0], 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
